// File: rtl/nios_pio_pkg.sv
// Shared constants for the Nios input PIO: Avalon register map and edge-capture modes.
package nios_pio_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [ADDR_W-1:0] {
        REG_DATA = 2'd0,
        REG_RSVD = 2'd1,
        REG_MASK = 2'd2,
        REG_EDGE = 2'd3
    } reg_addr_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/nios_pio_debounce_bit.sv
// Single-bit debounce filter: output follows the input only after it has differed
// from the output for DEBOUNCE_CYCLES consecutive clocks.
module nios_pio_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    output logic filtered
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            filtered <= RESET_VALUE;
        end else if (sample == filtered) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count    <= '0;
            filtered <= sample;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nios_pio_in_irq.sv
// Avalon-MM input PIO with 2-flop synchroniser, sticky edge capture, IRQ mask and level IRQ.
// Optional per-bit debounce filter enabled by defining NIOS_PIO_DEBOUNCE_EN.
module nios_pio_in_irq
    import nios_pio_pkg::*;
#(
    parameter int unsigned       WIDTH           = 4,
    parameter int unsigned       EDGE_MODE       = 0,
    parameter logic [WIDTH-1:0]  RESET_VALUE     = '0,
    parameter int unsigned       DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clear_bits;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [31:0]      read_mux;
    logic             wr;
    logic             unused_writedata;

    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= RESET_VALUE;
            sync2 <= RESET_VALUE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef NIOS_PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        nios_pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .sample   (sync2[i]),
            .filtered (data[i])
        );
    end
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign data = sync2;
`endif

    always_comb begin
        case (EDGE_MODE)
            EDGE_FALL: edges = ~data & prev;
            EDGE_ANY:  edges = data ^ prev;
            default:   edges = data & ~prev;
        endcase
    end

    assign wr         = chipselect && !write_n;
    assign clear_bits = (wr && address == REG_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        read_mux = '0;
        case (reg_addr_e'(address))
            REG_DATA: read_mux[WIDTH-1:0] = data;
            REG_MASK: read_mux[WIDTH-1:0] = irq_mask;
            REG_EDGE: read_mux[WIDTH-1:0] = edge_capture;
            default:  read_mux = '0;
        endcase
    end

    // New edges are OR-ed in after the clear so a coincident W1C never loses an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev         <= RESET_VALUE;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            prev         <= data;
            edge_capture <= (edge_capture & ~clear_bits) | edges;
            readdata     <= read_mux;
            if (wr && address == REG_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
